pic: RTL and testbench

PIC -- requirements
Module: pic

---
 rtl/pic.sv | 134 +++++++++++++
 tb/tb_pic.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pic.sv
// Keyboard-style parallel input controller: captures a byte on a device strobe,
// exposes it through a status/buffer register pair, and raises an active-low IRQ.
module pic (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] RW,
    input  logic       ADDR,
    input  logic [7:0] Din,
    output logic [7:0] Dout,
    output logic       IRQ,
    input  logic [7:0] PD,
    input  logic       TR,
    output logic       RDY
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPT     = 2'd1,
        WAIT_LOW = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] br_q, br_d;
    logic [7:0] dout_q, dout_d;
    logic       sr7_q, sr7_d;
    logic       sr6_q, sr6_d;
    logic       sr0_q, sr0_d;
    logic       irq_q, irq_d;
    logic       rdy_q, rdy_d;
    logic       tr_prev_q;

    logic [7:0] sr_s;
    logic       rd_sr_s, rd_br_s, wr_sr_s, tr_rise_s;

    // Bus decode and status register view
    always_comb begin
        sr_s      = {sr7_q, sr6_q, 5'b00000, sr0_q};
        rd_sr_s   = (RW == 2'b10) && (ADDR == 1'b0);
        rd_br_s   = (RW == 2'b10) && (ADDR == 1'b1);
        wr_sr_s   = (RW == 2'b11) && (ADDR == 1'b0);
        tr_rise_s = TR && !tr_prev_q;
    end

    // Next-state, register updates and output preparation
    always_comb begin
        state_d = state_q;
        br_d    = br_q;
        dout_d  = dout_q;
        sr7_d   = sr7_q;
        sr6_d   = sr6_q;
        sr0_d   = sr0_q;

        // Bus effects first so that device-side sets take priority over read clears
        if (rd_sr_s) begin
            dout_d = sr_s;
            sr6_d  = 1'b0;
        end else if (rd_br_s) begin
            dout_d = br_q;
            sr7_d  = 1'b0;
        end else if (wr_sr_s) begin
            sr0_d = Din[0];
        end else begin
            dout_d = dout_q;
        end

        case (state_q)
            IDLE: begin
                if (TR) begin
                    br_d    = PD;
                    sr7_d   = 1'b1;
                    state_d = CAPT;
                end else begin
                    state_d = IDLE;
                end
            end
            CAPT:     state_d = WAIT_LOW;
            WAIT_LOW: begin
                if (!TR) begin
                    state_d = HOLD;
                end else begin
                    state_d = WAIT_LOW;
                end
            end
            HOLD: begin
                if (!sr7_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default:  state_d = IDLE;
        endcase

        if (((state_q == WAIT_LOW) || (state_q == HOLD)) && tr_rise_s) begin
            sr6_d = 1'b1;
        end else begin
            sr6_d = sr6_d;
        end

        rdy_d = (state_d == IDLE);
        irq_d = ~(sr0_q & sr7_q);
    end

    // State and register flops with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            br_q      <= 8'h00;
            dout_q    <= 8'h00;
            sr7_q     <= 1'b0;
            sr6_q     <= 1'b0;
            sr0_q     <= 1'b0;
            irq_q     <= 1'b1;
            rdy_q     <= 1'b1;
            tr_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            br_q      <= br_d;
            dout_q    <= dout_d;
            sr7_q     <= sr7_d;
            sr6_q     <= sr6_d;
            sr0_q     <= sr0_d;
            irq_q     <= irq_d;
            rdy_q     <= rdy_d;
            tr_prev_q <= TR;
        end
    end

    assign Dout = dout_q;
    assign IRQ  = irq_q;
    assign RDY  = rdy_q;

endmodule

// File: tb/tb_pic.sv
// Directed bench for pic: transaction-level model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_pic;

    logic       CLK;
    logic       RST;
    logic [1:0] RW;
    logic       ADDR;
    logic [7:0] Din;
    logic [7:0] Dout;
    logic       IRQ;
    logic [7:0] PD;
    logic       TR;
    logic       RDY;

    int total = 0;
    int bad   = 0;

    pic dut (
        .CLK (CLK),
        .RST (RST),
        .RW  (RW),
        .ADDR(ADDR),
        .Din (Din),
        .Dout(Dout),
        .IRQ (IRQ),
        .PD  (PD),
        .TR  (TR),
        .RDY (RDY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a pending byte is "busy" until the device has let go of the strobe
    // and the CPU has consumed it.
    logic [7:0] m_br, m_dout, m_sr_now;
    logic       m_v, m_o, m_ie, m_irq, m_rdy, m_busy, m_released, m_tr_last;
    logic       m_rd_sr, m_rd_br, m_wr_sr, m_cap, m_ovr, m_v_n, m_o_n;
    int         m_age;
    logic       model_ok = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            m_br = 8'h00; m_dout = 8'h00; m_v = 1'b0; m_o = 1'b0; m_ie = 1'b0;
            m_irq = 1'b1; m_rdy = 1'b1; m_busy = 1'b0; m_released = 1'b0;
            m_tr_last = 1'b0; m_age = 0;
            model_ok = 1'b1;
        end else begin
            m_rd_sr  = (RW == 2'b10) && (ADDR == 1'b0);
            m_rd_br  = (RW == 2'b10) && (ADDR == 1'b1);
            m_wr_sr  = (RW == 2'b11) && (ADDR == 1'b0);
            m_sr_now = {m_v, m_o, 5'b00000, m_ie};
            m_cap = 1'b0;
            m_ovr = 1'b0;
            if (!m_busy) begin
                if (TR) m_cap = 1'b1;
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (!m_released) begin
                m_ovr = TR && !m_tr_last;
                if (!TR) m_released = 1'b1;
            end else begin
                m_ovr = TR && !m_tr_last;
                if (!m_v) m_busy = 1'b0;
            end
            m_irq = !(m_ie && m_v);
            if (m_rd_sr) m_dout = m_sr_now;
            else if (m_rd_br) m_dout = m_br;
            m_v_n = m_v;
            if (m_rd_br) m_v_n = 1'b0;
            if (m_cap) m_v_n = 1'b1;
            m_o_n = m_o;
            if (m_rd_sr) m_o_n = 1'b0;
            if (m_ovr) m_o_n = 1'b1;
            if (m_wr_sr) m_ie = Din[0];
            if (m_cap) begin
                m_br = PD; m_busy = 1'b1; m_age = 0; m_released = 1'b0;
            end
            m_v = m_v_n;
            m_o = m_o_n;
            m_rdy = !m_busy;
            m_tr_last = TR;
        end
    end

    always @(negedge CLK) begin
        if (model_ok) begin
            chk("model_dout", Dout, m_dout);
            chk("model_irq", {7'd0, IRQ}, {7'd0, m_irq});
            chk("model_rdy", {7'd0, RDY}, {7'd0, m_rdy});
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
        end
        #2;
    endtask

    task automatic bus(input logic [1:0] rw, input logic a, input logic [7:0] d);
        RW = rw; ADDR = a; Din = d;
    endtask

    initial begin
        RST = 1'b1; RW = 2'b00; ADDR = 1'b0; Din = 8'h00; PD = 8'h00; TR = 1'b0;
        cyc(2);
        RST = 1'b0;
        chk("rst_dout", Dout, 8'h00);
        chk("rst_irq", {7'd0, IRQ}, 8'h01);
        chk("rst_rdy", {7'd0, RDY}, 8'h01);

        // Polling path
        PD = 8'hA5; TR = 1'b1; cyc(1);
        TR = 1'b0;
        chk("poll_rdy_low", {7'd0, RDY}, 8'h00);
        cyc(2);
        bus(2'b10, 1'b0, 8'h00); cyc(1);
        chk("poll_sr", Dout, 8'h80);
        bus(2'b10, 1'b1, 8'h00); cyc(1);
        chk("poll_br", Dout, 8'hA5);
        bus(2'b00, 1'b0, 8'h00); cyc(1);
        chk("poll_rdy_back", {7'd0, RDY}, 8'h01);
        chk("poll_irq", {7'd0, IRQ}, 8'h01);
        cyc(1);

        // Interrupt path
        bus(2'b11, 1'b0, 8'h01); cyc(1);
        bus(2'b00, 1'b0, 8'h00);
        PD = 8'h3C; TR = 1'b1; cyc(1);
        TR = 1'b0;
        chk("int_irq_edge1", {7'd0, IRQ}, 8'h01);
        cyc(1);
        chk("int_irq_edge2", {7'd0, IRQ}, 8'h00);
        cyc(1);
        bus(2'b10, 1'b1, 8'h00); cyc(1);
        chk("int_br", Dout, 8'h3C);
        chk("int_irq_still", {7'd0, IRQ}, 8'h00);
        bus(2'b00, 1'b0, 8'h00); cyc(1);
        chk("int_irq_clear", {7'd0, IRQ}, 8'h01);
        bus(2'b11, 1'b0, 8'h00); cyc(1);
        bus(2'b00, 1'b0, 8'h00); cyc(1);

        // Overrun
        PD = 8'h11; TR = 1'b1; cyc(1);
        TR = 1'b0; cyc(2);
        PD = 8'h22; TR = 1'b1; cyc(1);
        TR = 1'b0; cyc(1);
        bus(2'b10, 1'b0, 8'h00); cyc(1);
        chk("ovr_sr", Dout, 8'hC0);
        bus(2'b10, 1'b1, 8'h00); cyc(1);
        chk("ovr_br", Dout, 8'h11);
        bus(2'b10, 1'b0, 8'h00); cyc(1);
        chk("ovr_sr2", Dout, 8'h00);
        bus(2'b00, 1'b0, 8'h00); cyc(2);

        // Long strobe
        PD = 8'h5A; TR = 1'b1; cyc(10);
        chk("long_rdy", {7'd0, RDY}, 8'h00);
        TR = 1'b0;
        bus(2'b10, 1'b0, 8'h00); cyc(1);
        chk("long_sr", Dout, 8'h80);
        bus(2'b10, 1'b1, 8'h00); cyc(1);
        chk("long_br", Dout, 8'h5A);
        bus(2'b00, 1'b0, 8'h00); cyc(1);
        chk("long_rdy_back", {7'd0, RDY}, 8'h01);
        cyc(1);

        // Reset mid-transfer, overriding bus and device activity
        bus(2'b11, 1'b0, 8'h01); cyc(1);
        bus(2'b00, 1'b0, 8'h00);
        PD = 8'h99; TR = 1'b1; cyc(2);
        chk("mid_irq_low", {7'd0, IRQ}, 8'h00);
        RST = 1'b1; bus(2'b10, 1'b1, 8'h00); cyc(1);
        RST = 1'b0; TR = 1'b0; bus(2'b00, 1'b0, 8'h00);
        chk("mid_rdy", {7'd0, RDY}, 8'h01);
        chk("mid_irq", {7'd0, IRQ}, 8'h01);
        chk("mid_dout", Dout, 8'h00);
        bus(2'b10, 1'b0, 8'h00); cyc(1);
        chk("mid_sr", Dout, 8'h00);
        bus(2'b10, 1'b1, 8'h00); cyc(1);
        chk("mid_br", Dout, 8'h00);
        bus(2'b00, 1'b0, 8'h00); cyc(1);

        // Bus corner: BR write ignored, RW=01 idles
        PD = 8'h42; TR = 1'b1; cyc(1);
        TR = 1'b0; cyc(2);
        bus(2'b11, 1'b1, 8'hFF); cyc(1);
        bus(2'b10, 1'b1, 8'h00); cyc(1);
        chk("corner_br", Dout, 8'h42);
        bus(2'b01, 1'b0, 8'hFF); cyc(3);
        chk("corner_hold", Dout, 8'h42);

        // BR read coincident with a capture in IDLE
        PD = 8'h66; TR = 1'b1; bus(2'b10, 1'b1, 8'h00); cyc(1);
        chk("same_cap_dout", Dout, 8'h42);
        TR = 1'b0; bus(2'b00, 1'b0, 8'h00); cyc(2);
        bus(2'b10, 1'b0, 8'h00); cyc(1);
        chk("same_cap_sr", Dout, 8'h80);

        // SR read coincident with an overrun
        TR = 1'b1; bus(2'b10, 1'b0, 8'h00); cyc(1);
        chk("same_ovr_dout", Dout, 8'h80);
        TR = 1'b0; bus(2'b00, 1'b0, 8'h00); cyc(1);
        bus(2'b10, 1'b0, 8'h00); cyc(1);
        chk("same_ovr_sr", Dout, 8'hC0);
        bus(2'b10, 1'b1, 8'h00); cyc(1);
        chk("same_ovr_br", Dout, 8'h66);

        // Stale BR read
        bus(2'b00, 1'b0, 8'h00); cyc(2);
        bus(2'b10, 1'b1, 8'h00); cyc(1);
        chk("stale_br", Dout, 8'h66);
        bus(2'b10, 1'b0, 8'h00); cyc(1);
        chk("stale_sr", Dout, 8'h00);
        bus(2'b00, 1'b0, 8'h00); cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
